// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle CPU control FSM: states, opcode
// classes, RV32 major opcodes and the pc_sel / wb_sel encodings.
package cpu_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_ECALL,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_SEL_PLUS4   = 2'd0;
    localparam logic [1:0] PC_SEL_PC_IMM  = 2'd1;
    localparam logic [1:0] PC_SEL_RS1_IMM = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    function automatic logic cls_is_mem(input op_class_t c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

    // Stores and branches are the only retiring classes with no rd update.
    function automatic logic cls_writes_reg(input op_class_t c);
        return !((c == CLS_STORE) || (c == CLS_BRANCH));
    endfunction

    function automatic logic [1:0] cls_pc_sel(input op_class_t c, input logic taken);
        if ((c == CLS_JAL) || ((c == CLS_BRANCH) && taken))
            return PC_SEL_PC_IMM;
        if (c == CLS_JALR)
            return PC_SEL_RS1_IMM;
        return PC_SEL_PLUS4;
    endfunction

    function automatic logic [1:0] cls_wb_sel(input op_class_t c);
        if (c == CLS_LOAD)
            return WB_SEL_MEM;
        if ((c == CLS_JAL) || (c == CLS_JALR))
            return WB_SEL_PC4;
        return WB_SEL_ALU;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_opcode_class.sv
// Combinational opcode classifier: maps inst[6:0] (and funct12 for SYSTEM)
// onto the instruction class the control FSM sequences by.
module opcode_class
    import cpu_ctrl_fsm_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [11:0] funct12,
    output op_class_t   op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: op_class = CLS_ALU;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_BRANCH: op_class = CLS_BRANCH;
            OPC_JAL:    op_class = CLS_JAL;
            OPC_JALR:   op_class = CLS_JALR;
            // Only ecall is recognised; other SYSTEM encodings are unsupported.
            OPC_SYSTEM: op_class = (funct12 == 12'h000) ? CLS_ECALL : CLS_ILLEGAL;
            default:    op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle RV32 control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT) with registered
// strobes. Define MEM_TIMEOUT_EN to bound FETCH/MEM waits at TIMEOUT_CYCLES.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic [11:0] funct12,
    input  logic        do_branch,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        reg_write,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        illegal,
    output logic        err_timeout,
    output logic [31:0] instret
);

    state_t    state;
    state_t    next_state;
    op_class_t dec_class;
    op_class_t cls_q;
    logic      fetch_win;
    logic      timeout_hit;

    opcode_class u_opcode_class (
        .opcode   (opcode),
        .funct12  (funct12),
        .op_class (dec_class)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;
    logic             wait_entry;

    assign in_wait     = (state == ST_FETCH) || (state == ST_MEM);
    assign wait_entry  = (next_state != state) &&
                         ((next_state == ST_FETCH) || (next_state == ST_MEM));
    assign timeout_hit = in_wait && !mem_ack &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (wait_entry)
                wait_cnt <= '0;
            else if (in_wait && !mem_ack)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (run)
                    next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack)
                    next_state = ST_DECODE;
                else if (timeout_hit)
                    next_state = ST_HALT;
            end
            ST_DECODE: begin
                if ((dec_class == CLS_ECALL) || (dec_class == CLS_ILLEGAL))
                    next_state = ST_HALT;
                else
                    next_state = ST_EXEC;
            end
            ST_EXEC: begin
                next_state = cls_is_mem(cls_q) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (mem_ack)
                    next_state = ST_WB;
                else if (timeout_hit)
                    next_state = ST_HALT;
            end
            ST_WB: begin
                next_state = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the state being entered, so each one is
    // valid for exactly the cycles the FSM spends in that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cls_q     <= CLS_ALU;
            fetch_win <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            reg_write <= 1'b0;
            pc_we     <= 1'b0;
            pc_sel    <= PC_SEL_PLUS4;
            wb_sel    <= WB_SEL_ALU;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            instret   <= '0;
        end else begin
            state     <= next_state;
            if (state == ST_DECODE)
                cls_q <= dec_class;
            fetch_win <= (next_state == ST_FETCH);
            mem_req   <= (next_state == ST_FETCH) || (next_state == ST_MEM);
            mem_we    <= (next_state == ST_MEM) && (cls_q == CLS_STORE);
            pc_we     <= (next_state == ST_WB);
            reg_write <= (next_state == ST_WB) && cls_writes_reg(cls_q);
            pc_sel    <= (next_state == ST_WB) ? cls_pc_sel(cls_q, do_branch) : PC_SEL_PLUS4;
            wb_sel    <= (next_state == ST_WB) ? cls_wb_sel(cls_q) : WB_SEL_ALU;
            halted    <= (next_state == ST_HALT);
            if ((state == ST_DECODE) && (dec_class == CLS_ILLEGAL))
                illegal <= 1'b1;
            if (next_state == ST_WB)
                instret <= instret + 32'd1;
        end
    end

    // The fetch window is registered; ack qualifies it so only the returning
    // instruction word is written into IR, never a stale bus value.
    assign ir_we = fetch_win && mem_ack;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed + randomized bench for cpu_ctrl_fsm; expectations come from a
// per-instruction phase model (cycle counts and strobes per instruction class).
module tb_cpu_ctrl_fsm;

    localparam int TB_TIMEOUT = 4;

    localparam int K_ALU   = 0;
    localparam int K_LD    = 1;
    localparam int K_ST    = 2;
    localparam int K_BR    = 3;
    localparam int K_JAL   = 4;
    localparam int K_JALR  = 5;
    localparam int K_ECALL = 6;
    localparam int K_ILL   = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [6:0]  opcode;
    logic [11:0] funct12;
    logic        do_branch;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        reg_write;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic        halted;
    logic        illegal;
    logic        err_timeout;
    logic [31:0] instret;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_instret;

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                  7'b0010111};

    cpu_ctrl_fsm #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .opcode      (opcode),
        .funct12     (funct12),
        .do_branch   (do_branch),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ir_we       (ir_we),
        .reg_write   (reg_write),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .wb_sel      (wb_sel),
        .halted      (halted),
        .illegal     (illegal),
        .err_timeout (err_timeout),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [6:0] opc, input logic [11:0] f12);
        case (opc)
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return K_ALU;
            7'b1110011: return (f12 == 12'd0) ? K_ECALL : K_ILL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // {mem_req, mem_we, ir_we, reg_write, pc_we, pc_sel, wb_sel, halted, illegal, err_timeout}
    function automatic logic [11:0] mk(input logic req, input logic we, input logic ir,
                                       input logic rw, input logic pcwe, input logic [1:0] ps,
                                       input logic [1:0] ws, input logic h, input logic il,
                                       input logic to);
        return {req, we, ir, rw, pcwe, ps, ws, h, il, to};
    endfunction

    task automatic chk(input logic [11:0] exp, input string tag);
        logic [11:0] obs;
        obs = {mem_req, mem_we, ir_we, reg_write, pc_we, pc_sel, wb_sel, halted, illegal, err_timeout};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s outputs got %b want %b (req we ir rw pcwe pcsel wbsel hlt ill tmo)",
                   tag, obs, exp);
        end
        n_checks++;
        assert (instret === exp_instret) else begin
            n_errors++;
            $error("FAIL %s instret got %0d want %0d", tag, instret, exp_instret);
        end
    endtask

    // One clock: inputs for this cycle go in after the edge, outputs checked after settling.
    task automatic cyc(input logic ack, input logic rn, input logic [11:0] exp, input string tag);
        @(posedge clk);
        #1;
        mem_ack = ack;
        run     = rn;
        #1;
        chk(exp, tag);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        run     = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_instret = '0;
        #1;
        chk(12'd0, "reset_state");
    endtask

    // Precondition: the next clock edge moves the FSM into FETCH.
    task automatic run_instr(input logic [6:0] opc, input logic [11:0] f12, input logic db,
                             input int wf, input int wm, input logic run_after,
                             output logic stopped);
        int         k;
        logic       st;
        logic       rw;
        logic [1:0] ps;
        logic [1:0] ws;
        k  = classify(opc, f12);
        st = (k == K_ST);
        rw = !((k == K_ST) || (k == K_BR));
        ps = ((k == K_JAL) || ((k == K_BR) && db)) ? 2'd1 : ((k == K_JALR) ? 2'd2 : 2'd0);
        ws = (k == K_LD) ? 2'd1 : (((k == K_JAL) || (k == K_JALR)) ? 2'd2 : 2'd0);
        opcode    = opc;
        funct12   = f12;
        do_branch = db;
        stopped   = 1'b0;
        for (int i = 0; i < wf; i++)
            cyc(1'b0, rnd(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), "fetch_wait");
        cyc(1'b1, rnd(), mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), "fetch_ack");
        cyc(rnd(), rnd(), 12'd0, "decode");
        if ((k == K_ECALL) || (k == K_ILL)) begin
            cyc(rnd(), rnd(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, (k == K_ILL), 1'b0),
                "halt_entry");
            stopped = 1'b1;
            return;
        end
        cyc(rnd(), rnd(), 12'd0, "exec");
        if ((k == K_LD) || (k == K_ST)) begin
            for (int i = 0; i < wm; i++)
                cyc(1'b0, rnd(), mk(1'b1, st, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), "mem_wait");
            cyc(1'b1, rnd(), mk(1'b1, st, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), "mem_ack");
        end
        exp_instret = exp_instret + 32'd1;
        cyc(rnd(), run_after, mk(1'b0, 1'b0, 1'b0, rw, 1'b1, ps, ws, 1'b0, 1'b0, 1'b0), "wb");
        if (!run_after) begin
            cyc(rnd(), 1'b0, 12'd0, "idle_hold");
            cyc(rnd(), 1'b1, 12'd0, "idle_start");
        end
    endtask

    task automatic absorb(input int n, input logic il, input logic to, input string tag);
        for (int i = 0; i < n; i++)
            cyc(rnd(), rnd(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, il, to), tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       stop;
        logic [6:0] opc_r;
        n_checks    = 0;
        n_errors    = 0;
        exp_instret = '0;
        rst         = 1'b1;
        run         = 1'b0;
        mem_ack     = 1'b0;
        do_branch   = 1'b0;
        opcode      = 7'd0;
        funct12     = 12'd0;

        do_reset();
        cyc(1'b1, 1'b0, 12'd0, "idle_ack_ignored");
        cyc(1'b0, 1'b1, 12'd0, "idle_start");

        run_instr(7'b0110011, 12'd0, 1'b0, 0, 0, 1'b1, stop);
        run_instr(7'b0000011, 12'd0, 1'b0, 0, 3, 1'b1, stop);
        run_instr(7'b0100011, 12'd0, 1'b0, 1, 0, 1'b1, stop);
        run_instr(7'b1100011, 12'd0, 1'b1, 0, 0, 1'b1, stop);
        run_instr(7'b1100011, 12'd0, 1'b0, 0, 0, 1'b1, stop);
        run_instr(7'b1101111, 12'd0, 1'b0, 0, 0, 1'b1, stop);
        run_instr(7'b1100111, 12'd0, 1'b0, 2, 0, 1'b1, stop);
        run_instr(7'b0110111, 12'd0, 1'b0, 0, 0, 1'b0, stop);
        run_instr(7'b0010111, 12'd0, 1'b0, 0, 0, 1'b1, stop);
        run_instr(7'b0010011, 12'd5, 1'b1, 3, 0, 1'b0, stop);

        for (int n = 0; n < 40; n++)
            run_instr(legal_ops[$urandom_range(0, 8)], 12'($urandom), rnd(),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 3) != 0), stop);

        // Asynchronous reset in the middle of a load's memory wait.
        opcode = 7'b0000011;
        cyc(1'b1, 1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), "r_fetch");
        cyc(1'b0, 1'b1, 12'd0, "r_decode");
        cyc(1'b0, 1'b1, 12'd0, "r_exec");
        cyc(1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), "r_mem");
        rst = 1'b1;
        exp_instret = '0;
        #1;
        chk(12'd0, "rst_mid_mem");
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        #1;
        chk(12'd0, "rst_held");
        rst = 1'b0;
        run = 1'b0;
        cyc(1'b1, 1'b0, 12'd0, "post_rst_idle");
        cyc(1'b1, 1'b0, 12'd0, "post_rst_idle2");
        cyc(1'b0, 1'b1, 12'd0, "post_rst_start");
        run_instr(7'b0110011, 12'd0, 1'b0, 0, 0, 1'b1, stop);

        run_instr(7'b1111111, 12'd0, 1'b0, 0, 0, 1'b1, stop);
        absorb(8, 1'b1, 1'b0, "ill_absorb");
        do_reset();
        cyc(1'b0, 1'b1, 12'd0, "idle_start");
        run_instr(7'b1110011, 12'd0, 1'b0, 1, 0, 1'b1, stop);
        absorb(4, 1'b0, 1'b0, "ecall_absorb");
        do_reset();
        cyc(1'b0, 1'b1, 12'd0, "idle_start");

        for (int n = 0; n < 20; n++) begin
            opc_r = 7'($urandom);
            run_instr(opc_r, 12'd0, rnd(), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), 1'b1, stop);
            if (stop) begin
                absorb(3, (classify(opc_r, 12'd0) == K_ILL), 1'b0, "rand_absorb");
                do_reset();
                cyc(rnd(), 1'b1, 12'd0, "idle_start");
            end
        end

        do_reset();
        cyc(1'b0, 1'b1, 12'd0, "idle_start");
        opcode = 7'b0110011;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < TB_TIMEOUT; i++)
            cyc(1'b0, rnd(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), "to_wait");
        cyc(rnd(), rnd(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1), "to_halt");
        absorb(3, 1'b0, 1'b1, "to_absorb");
`else
        for (int i = 0; i < 100; i++)
            cyc(1'b0, rnd(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), "no_to_wait");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the memory-wait cycle limit when MEM_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port run  input  1  start/continue enable, sampled in IDLE.
REQ-005 SHALL have port opcode  input  7  inst[6:0] of the instruction register.
REQ-006 SHALL have port funct12  input  12  inst[31:20], used to decode SYSTEM.
REQ-007 SHALL have port do_branch  input  1  branch-taken flag from the decoder.
REQ-008 SHALL have port mem_ack  input  1  memory completion for the current request.
REQ-009 SHALL have outputs mem_req, mem_we, ir_we, reg_write, pc_we  output  1 each  datapath strobes.
REQ-010 SHALL have output pc_sel  output  2  next-PC select: 0=PC+4, 1=PC+imm, 2=rs1+imm (JALR).
REQ-011 SHALL have output wb_sel  output  2  writeback source: 0=ALU, 1=memory, 2=PC+4.
REQ-012 SHALL have outputs halted, illegal, err_timeout  output  1 each  sticky status.
REQ-013 SHALL have output instret  output  32  retired-instruction count.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT; all outputs are registered.
REQ-015 IDLE SHALL go to FETCH when run=1 and stay otherwise.
REQ-016 FETCH SHALL hold mem_req=1 and mem_we=0 until mem_ack=1, pulse ir_we in the ack cycle, then enter DECODE.
REQ-017 DECODE SHALL last exactly one cycle; SYSTEM (1110011) with funct12=0 (ecall) goes to HALT; unlisted opcodes set illegal=1 and go to HALT; all others go to EXEC.
REQ-018 Legal opcodes SHALL be 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111 and 0010111.
REQ-019 EXEC SHALL last one cycle, going to MEM for load/store and to WB otherwise.
REQ-020 MEM SHALL hold mem_req=1, with mem_we=1 for store, until mem_ack, then enter WB.
REQ-021 WB SHALL pulse pc_we for one cycle; it SHALL pulse reg_write for every class except store and branch; it SHALL increment instret (mod 2^32); it SHALL then go to FETCH if run=1, else to IDLE.
REQ-022 pc_sel in WB SHALL be 1 for JAL and for a branch with do_branch=1, 2 for JALR, and 0 otherwise.
REQ-023 wb_sel in WB SHALL be 1 for load, 2 for JAL/JALR, and 0 otherwise.
REQ-024 Latency with zero-wait memory SHALL be 4 cycles for ALU/branch/jump/LUI/AUIPC and 5 cycles for load/store.
REQ-025 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-026 HALT SHALL be absorbing: all strobes 0, halted=1; only rst exits it.

Reset
REQ-027 On rst, the FSM SHALL enter IDLE and all strobes, pc_sel, wb_sel, halted, illegal, err_timeout and instret SHALL be 0, even mid-request.
REQ-028 The first request after reset SHALL appear no earlier than the cycle after run is sampled high in IDLE.

Configuration
REQ-029 When MEM_TIMEOUT_EN is defined, a wait counter SHALL clear on entry to FETCH/MEM, count each cycle without mem_ack, and on reaching TIMEOUT_CYCLES set err_timeout=1 and go to HALT.
REQ-030 When MEM_TIMEOUT_EN is undefined, waits SHALL be unbounded, no counter SHALL be built, and err_timeout SHALL be tied to 0.

Structure
REQ-031 A shared package SHALL hold the state enum, the opcode constants, and the pc_sel/wb_sel encodings.
REQ-032 Opcode classification SHALL be one combinational sub-module named opcode_class; no other sub-modules.

Verification
REQ-033 run=1, zero-wait memory, opcode=0110011 -> ir_we at cycle 1, reg_write+pc_we at cycle 4, wb_sel=0, pc_sel=0, instret=1.
REQ-034 Load with mem_ack delayed 3 cycles in MEM -> mem_req high for 4 cycles, reg_write with wb_sel=1, total 8 cycles.
REQ-035 Branch with do_branch=1 -> pc_sel=1, reg_write=0; with do_branch=0 -> pc_sel=0.
REQ-036 opcode=1111111 -> illegal=1, halted=1; later mem_ack pulses and run toggles cause no strobes until rst.
REQ-037 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack in FETCH -> err_timeout=1 and HALT after 4 cycles; without the macro -> still in FETCH after 100 cycles.
REQ-038 rst asserted mid-MEM -> all outputs 0 immediately, instret=0, IDLE on release.
